// File: rtl/pdh_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : pdh_cmd_master
// Purpose  : Fabric-side initiator for the PDH core 32-bit GPIO command word.
//            Accepts {cmd, data} requests, sequences setup / strobe / settle
//            phases on the command word, then polls the callback word until
//            its command field echoes the issued command (or a timeout
//            expires) and returns the captured callback word.
// Ports    : clk, rst_ni            - clock, synchronous active-low reset
//            req_*                  - request handshake {cmd, data, nostrobe}
//            rsp_*                  - response handshake {data, timeout}
//            core_rst_req_i         - level request for a core reset pulse
//            gpio_to_core_o         - {rst, strobe, cmd[3:0], data[25:0]}
//            gpio_from_core_i       - callback word, [31:28] = echoed cmd
//            busy_o                 - high whenever the master is not idle
// Revision : 1.0 - initial release
// ============================================================================
module pdh_cmd_master #(
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RST_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_cmd_i,
  input  logic [25:0] req_data_i,
  input  logic        req_nostrobe_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_timeout_o,
  input  logic        core_rst_req_i,
  output logic [31:0] gpio_to_core_o,
  input  logic [31:0] gpio_from_core_i,
  output logic        busy_o
);

  // Counter is sized for the largest phase length.
  localparam int MAX_AB  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CD  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_P   = (MAX_ABCD > RST_CYCLES) ? MAX_ABCD : RST_CYCLES;
  localparam int CW      = $clog2(MAX_P + 1);

  // Each phase reloads with (length - 1) and leaves when the counter is zero.
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  // The first callback sample is taken on the edge that ends SETTLE, so
  // WAIT_CB only has TIMEOUT_CYCLES-1 samples left and reloads with one less.
  localparam logic [CW-1:0] WAIT_LOAD   = CW'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);
  localparam bit            TIMEOUT_ONE = (TIMEOUT_CYCLES == 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CORE_RST = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    SETTLE   = 3'd4,
    WAIT_CB  = 3'd5,
    RESP     = 3'd6
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      cmd_lat;
  logic            nostrobe_lat;

  logic            cb_match;
  logic            last_sample;

  assign cb_match    = (gpio_from_core_i[31:28] == cmd_lat);
  // In SETTLE the only sample taken is sample 0.
  assign last_sample = (state == SETTLE) ? TIMEOUT_ONE : (cnt == '0);

  assign req_ready_o = (state == IDLE) && !core_rst_req_i;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      cmd_lat        <= '0;
      nostrobe_lat   <= 1'b0;
      gpio_to_core_o <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_data_o     <= '0;
      rsp_timeout_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gpio_to_core_o <= '0;
          if (core_rst_req_i) begin
            state          <= CORE_RST;
            gpio_to_core_o <= 32'h8000_0000;
            cnt            <= RST_LOAD;
          end else if (req_valid_i) begin
            cmd_lat        <= req_cmd_i;
            nostrobe_lat   <= req_nostrobe_i;
            gpio_to_core_o <= {2'b00, req_cmd_i, req_data_i};
            state          <= SETUP;
            cnt            <= SETUP_LOAD;
          end
        end

        CORE_RST: begin
          if (cnt == '0) begin
            state          <= IDLE;
            gpio_to_core_o <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            if (nostrobe_lat) begin
              state <= SETTLE;
              cnt   <= SETTLE_LOAD;
            end else begin
              state              <= STROBE;
              gpio_to_core_o[30] <= 1'b1;
              cnt                <= HOLD_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STROBE: begin
          if (cnt == '0) begin
            state              <= SETTLE;
            gpio_to_core_o[30] <= 1'b0;
            cnt                <= SETTLE_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // SETTLE's final edge doubles as callback sample 0; WAIT_CB takes
        // the remaining samples.
        SETTLE, WAIT_CB: begin
          if ((state == SETTLE) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
          end else if (cb_match || last_sample) begin
            rsp_data_o     <= gpio_from_core_i;
            rsp_timeout_o  <= !cb_match;
            rsp_valid_o    <= 1'b1;
            gpio_to_core_o <= '0;
            state          <= RESP;
          end else begin
            state <= WAIT_CB;
            cnt   <= (state == SETTLE) ? WAIT_LOAD : cnt - 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state          <= IDLE;
          gpio_to_core_o <= '0;
          rsp_valid_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pdh_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdh_cmd_master
// Purpose  : Self-checking bench for pdh_cmd_master with a small PDH core
//            callback model; table-driven command vectors plus directed
//            sequences for reset, backpressure and core-reset requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdh_cmd_master;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_cmd_i;
  logic [25:0] req_data_i;
  logic        req_nostrobe_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_timeout_o;
  logic        core_rst_req_i;
  logic [31:0] gpio_to_core_o;
  logic [31:0] gpio_from_core_i;
  logic        busy_o;

  always #5 clk = ~clk;

  pdh_cmd_master dut (
    .clk              (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_cmd_i        (req_cmd_i),
    .req_data_i       (req_data_i),
    .req_nostrobe_i   (req_nostrobe_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_timeout_o    (rsp_timeout_o),
    .core_rst_req_i   (core_rst_req_i),
    .gpio_to_core_o   (gpio_to_core_o),
    .gpio_from_core_i (gpio_from_core_i),
    .busy_o           (busy_o)
  );

  // Core model. Mode 0: latch {cmd, 00, data} as echo when strobe is seen.
  // Mode 1: read-only command 3 answers 0x30000ABC without a strobe.
  // Mode 2: callback stuck at zero.
  int core_mode;
  always @(posedge clk) begin
    if (!rst_ni) gpio_from_core_i <= 32'h0;
    else begin
      case (core_mode)
        0: if (gpio_to_core_o[30])
             gpio_from_core_i <= {gpio_to_core_o[29:26], 2'b00, gpio_to_core_o[25:0]};
        1: gpio_from_core_i <= (gpio_to_core_o[29:26] == 4'd3) ? 32'h30000ABC : 32'h0;
        default: gpio_from_core_i <= 32'h0;
      endcase
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Present a request at a negedge; returns #1 after the accept edge E0.
  task automatic issue(input logic [3:0] cmd, input logic [25:0] data, input logic nostb);
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_cmd_i      = cmd;
    req_data_i     = data;
    req_nostrobe_i = nostb;
    #1;
    check("req_ready_before_accept", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("word_after_accept", gpio_to_core_o, {2'b00, cmd, data});
  endtask

  // Step edges until rsp_valid_o is seen; lat = edges counted from start.
  task automatic run_to_rsp(output int lat, output int sfirst, output int scnt, output logic b31);
    lat = -1; sfirst = -1; scnt = 0; b31 = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (gpio_to_core_o[30]) begin
        if (sfirst < 0) sfirst = n;
        scnt++;
      end
      if (gpio_to_core_o[31]) b31 = 1'b1;
      if (rsp_valid_o) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      $display("FAIL rsp_wait: no rsp_valid within 200 cycles, expected a response");
    end
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [25:0] data;
    logic        nostb;
    int          mode;
    int          lat;
    int          stb_first;
    int          stb_cnt;
    logic [31:0] rdata;
    logic        tmo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          lat, sf, sc;
    logic        b31;
    logic        bad;
    int          hi;

    vecs[0] = '{4'd1, 26'h00000A5, 1'b0, 0, 8,  2,  2, 32'h100000A5, 1'b0}; // SET_LED
    vecs[1] = '{4'd3, 26'h0000007, 1'b1, 1, 6,  -1, 0, 32'h30000ABC, 1'b0}; // GET_ADC
    vecs[2] = '{4'd0, 26'h0000000, 1'b0, 2, 8,  2,  2, 32'h00000000, 1'b0}; // cmd 0
    vecs[3] = '{4'd2, 26'h2AAAAAA, 1'b0, 2, 71, 2,  2, 32'h00000000, 1'b1}; // timeout
    vecs[4] = '{4'd5, 26'h3FFFFFF, 1'b0, 0, 8,  2,  2, 32'h53FFFFFF, 1'b0}; // full data

    rst_ni = 1'b0; req_valid_i = 1'b0; req_cmd_i = '0; req_data_i = '0;
    req_nostrobe_i = 1'b0; rsp_ready_i = 1'b1; core_rst_req_i = 1'b0;
    core_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word",      gpio_to_core_o, 32'h0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rsp_data",  rsp_data_o, 32'h0);
    check("rst_rsp_tmo",   {31'd0, rsp_timeout_o}, 32'd0);
    check("rst_busy",      {31'd0, busy_o}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;

    // ---------------- table-driven commands ----------------
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      core_mode = vecs[i].mode;
      issue(vecs[i].cmd, vecs[i].data, vecs[i].nostb);
      run_to_rsp(lat, sf, sc, b31);
      check($sformatf("v%0d_latency", i),   32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_stb_first", i), 32'(sf),  32'(vecs[i].stb_first));
      check($sformatf("v%0d_stb_cnt", i),   32'(sc),  32'(vecs[i].stb_cnt));
      check($sformatf("v%0d_rsp_data", i),  rsp_data_o, vecs[i].rdata);
      check($sformatf("v%0d_rsp_tmo", i),   {31'd0, rsp_timeout_o}, {31'd0, vecs[i].tmo});
      check($sformatf("v%0d_word_in_resp", i), gpio_to_core_o, 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid_clear", i), {31'd0, rsp_valid_o}, 32'd0);
      check($sformatf("v%0d_idle", i),        {31'd0, busy_o}, 32'd0);
    end

    // ---------------- reset during STROBE ----------------
    @(negedge clk);
    core_mode = 0;
    issue(4'd1, 26'h00000A5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_strobe_high", {31'd0, gpio_to_core_o[30]}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("midrst_word",      gpio_to_core_o, 32'h0);
    check("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (rsp_valid_o || busy_o) bad = 1'b1;
    end
    check("midrst_no_response", {31'd0, bad}, 32'd0);

    // ---------------- response backpressure ----------------
    @(negedge clk);
    rsp_ready_i = 1'b0;
    issue(4'd1, 26'h000005A, 1'b0);
    run_to_rsp(lat, sf, sc, b31);
    check("bp_latency", 32'(lat), 32'd8);
    check("bp_rsp_data", rsp_data_o, 32'h1000005A);
    @(negedge clk);
    req_valid_i = 1'b1; req_cmd_i = 4'd4; req_data_i = 26'h1;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid_o || rsp_data_o !== 32'h1000005A || req_ready_o ||
          gpio_to_core_o !== 32'h0 || !busy_o) bad = 1'b1;
    end
    check("bp_hold_stable", {31'd0, bad}, 32'd0);
    @(negedge clk);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("bp_release_idle",  {31'd0, busy_o}, 32'd0);
    check("bp_data_holds",    rsp_data_o, 32'h1000005A);

    // ---------------- core reset with pending request ----------------
    @(negedge clk);
    core_rst_req_i = 1'b1;
    req_valid_i = 1'b1; req_cmd_i = 4'd1; req_data_i = 26'h11; req_nostrobe_i = 1'b0;
    #1;
    check("crst_ready_low", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    hi = (gpio_to_core_o === 32'h8000_0000) ? 1 : 0;
    @(negedge clk);
    core_rst_req_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (gpio_to_core_o === 32'h8000_0000) hi++;
    end
    check("crst_high_cycles", 32'(hi), 32'd4);
    @(posedge clk); #1;
    check("crst_word_cleared", gpio_to_core_o, 32'h0);
    check("crst_back_idle",    {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("crst_then_accept", gpio_to_core_o, 32'h04000011);
    run_to_rsp(lat, sf, sc, b31);
    check("crst_cmd_rsp", rsp_data_o, 32'h10000011);
    @(posedge clk); #1;

    // ---------------- core reset deferred while busy ----------------
    @(negedge clk);
    issue(4'd6, 26'h0000123, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    core_rst_req_i = 1'b1;
    run_to_rsp(lat, sf, sc, b31);
    check("defer_no_b31_busy", {31'd0, b31}, 32'd0);
    check("defer_latency",     32'(lat), 32'd6);
    check("defer_rsp_data",    rsp_data_o, 32'h60000123);
    @(posedge clk); #1;
    check("defer_idle_word", gpio_to_core_o, 32'h0);
    check("defer_idle",      {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    check("defer_core_rst", gpio_to_core_o, 32'h8000_0000);
    @(negedge clk);
    core_rst_req_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("defer_done_idle", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdh_cmd_master.md
# pdh_cmd_master

PL-side command initiator for the PDH core's 32-bit GPIO command word protocol. It accepts `{cmd, data}` requests over a valid/ready handshake and drives the command word toward the core. It sequences setup, strobe and settle phases, then polls the core's 32-bit callback word until its command field echoes the issued command, or until a timeout. The result is returned over a second valid/ready handshake. It lets fabric logic (sweep and lock sequencers) issue the same commands as the PS without PS involvement.

## Interface
Parameters:
- `SETUP_CYCLES`, 2, cycles the word is held with strobe low before strobe rises (≥1)
- `HOLD_CYCLES`, 2, cycles strobe is held high (≥1)
- `SETTLE_CYCLES`, 4, cycles after strobe falls before the first callback sample (≥1)
- `TIMEOUT_CYCLES`, 64, maximum callback samples before timeout (≥1)
- `RST_CYCLES`, 4, cycles bit 31 (core reset) is held high on a core-reset request (≥1)

Ports:
- `clk` in 1: single clock; core and master share it
- `rst_ni` in 1: synchronous, active-low reset
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: request ready; high only in IDLE with no pending core reset
- `req_cmd_i` in 4: command code, placed in word bits [29:26]
- `req_data_i` in 26: payload, placed in word bits [25:0]
- `req_nostrobe_i` in 1: skip the strobe phase (read-only commands such as GET_ADC and CHECK_SIGNED)
- `rsp_valid_o` out 1: response valid
- `rsp_ready_i` in 1: response accept
- `rsp_data_o` out 32: captured callback word
- `rsp_timeout_o` out 1: response produced by timeout
- `core_rst_req_i` in 1: request a core reset pulse (level, sampled in IDLE)
- `gpio_to_core_o` out 32: command word `{rst, strobe, cmd[3:0], data[25:0]}`, registered
- `gpio_from_core_i` in 32: callback word; bits [31:28] carry the echoed command
- `busy_o` out 1: state ≠ IDLE

## Operation
- States: IDLE, CORE_RST, SETUP, STROBE, SETTLE, WAIT_CB, RESP.
- **IDLE:**
  - `gpio_to_core_o` = 0.
  - If `core_rst_req_i`, go to CORE_RST. This takes priority over a request, and `req_ready_o` is low that cycle.
  - Otherwise, on `req_valid_i && req_ready_o`: latch cmd, data and nostrobe; the word becomes `{0,0,cmd,data}`; go to SETUP.
- **CORE_RST:** bit 31 = 1, all other bits 0, for RST_CYCLES cycles, then return to IDLE with the word at 0.
- **SETUP:** hold `{0,0,cmd,data}` for SETUP_CYCLES. Then go to STROBE (bit 30 = 1), or go directly to SETTLE if nostrobe.
- **STROBE:** bit 30 high for exactly HOLD_CYCLES, then low; go to SETTLE.
- **SETTLE:** SETTLE_CYCLES cycles with strobe low and cmd/data held, then go to WAIT_CB.
- **WAIT_CB:** each cycle, compare `gpio_from_core_i[31:28]` with the latched cmd.
  - On a match: capture the full word into `rsp_data_o` with `rsp_timeout_o` = 0.
  - On the TIMEOUT_CYCLES-th unmatched sample: capture that sample with `rsp_timeout_o` = 1.
  - Either way, the word goes to 0 at the same edge and the state becomes RESP.
- **RESP:**
  - `rsp_valid_o` = 1; `rsp_data_o` and `rsp_timeout_o` are stable.
  - On `rsp_ready_i`, go to IDLE and clear `rsp_valid_o` at that edge.
  - `rsp_data_o` holds its last value until the next capture.
- **Command 0 (IDLE):** the core callback is all-zero, which matches cmd 0, so the command completes on its first sample.
- **Counters:** a single down-counter reloaded on each state entry, width `$clog2(max parameter + 1)`. No wrap-around; a counter at zero forces the state transition.
- **Simultaneous events:**
  - `core_rst_req_i` asserted while busy is ignored until IDLE. It is a level, so it is then honoured if still high.
  - A new request arriving while RESP is held is not accepted.

## Timing
- **Reset** (`rst_ni` low at an edge), values after the edge:
  - `gpio_to_core_o` = 0, state = IDLE.
  - `rsp_valid_o` = 0, `rsp_data_o` = 0, `rsp_timeout_o` = 0, `busy_o` = 0.
  - `req_ready_o` = 1 unless `core_rst_req_i` is high.
- **Reset mid-operation:** any state aborts, strobe drops at that edge, and no response is produced.
- **Edge timeline**, with E0 = the accept edge:
  - Word valid from E0.
  - Strobe rises at E0+SETUP and falls at E0+SETUP+HOLD.
  - First sample at E0+SETUP+HOLD+SETTLE, i.e. E0+8 with defaults.
  - With nostrobe: first sample at E0+SETUP+SETTLE.
- **Response timing:** a match on sample k (k = 0 first) raises `rsp_valid_o` after edge first+k.
- **Timeout:** `rsp_valid_o` rises after edge first+TIMEOUT_CYCLES−1.
- **Back-to-back:** minimum of one IDLE cycle (word = 0) between commands.

## Test plan
- **Reset:** drive `rst_ni` low for one cycle during STROBE → next cycle `gpio_to_core_o` = 0, `rsp_valid_o` = 0, `req_ready_o` = 1; no response is ever emitted.
- **SET_LED with core model:** cmd 1, data 0xA5 → bit 30 high exactly 2 cycles starting E0+2. `rsp_valid_o` rises after E0+8 with `rsp_data_o` = 0x100000A5 and `rsp_timeout_o` = 0.
- **GET_ADC with nostrobe:** cmd 3 → bit 30 never high; response after E0+6 with `rsp_data_o[31:28]` = 3.
- **Timeout:** cmd 2 with callback stuck at 0 → response after E0+71 (first sample E0+8, timeout after E0+8+63) with `rsp_timeout_o` = 1 and `rsp_data_o` = 0.
- **Response backpressure:** hold `rsp_ready_i` low for 10 cycles → `rsp_valid_o` and `rsp_data_o` stable, `req_ready_o` = 0, word = 0. The state returns to IDLE the edge after `rsp_ready_i` rises.
- **Core reset request:**
  - Pulse `core_rst_req_i` with `req_valid_i` high in IDLE → bit 31 high for 4 cycles (word = 0x80000000), then the request is accepted.
  - Assert `core_rst_req_i` while busy → it is deferred until IDLE.
